// File: rtl/bcd_to_bin_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_converter
// Brief    : Sequential 3-digit packed-BCD to 10-bit binary converter using
//            reverse double-dabble, one shift/adjust iteration per clock,
//            with a start/busy/done handshake and an invalid-digit flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] bcd_in,
    output logic [9:0]  bin_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam logic [3:0] C_LAST_ITER = 4'd9;

    state_t      r_state;
    state_t      w_state_next;
    logic [21:0] r_sr;
    logic [21:0] w_sr_iter;
    logic [3:0]  r_cnt;
    logic [9:0]  r_bin;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_digit_bad;
    logic        w_last;

    // Any nibble above 9 makes the whole operand unconvertible.
    assign w_digit_bad = (bcd_in[11:8] > 4'd9) |
                         (bcd_in[7:4]  > 4'd9) |
                         (bcd_in[3:0]  > 4'd9);

    assign w_last = (r_cnt == C_LAST_ITER);

    // One reverse double-dabble step: shift right, then pull each BCD field
    // that reached 8 or more back down by 3 (fields never borrow from each other).
    always_comb begin
        w_sr_iter = r_sr >> 1;
        if (w_sr_iter[21:18] >= 4'd8) w_sr_iter[21:18] = w_sr_iter[21:18] - 4'd3;
        if (w_sr_iter[17:14] >= 4'd8) w_sr_iter[17:14] = w_sr_iter[17:14] - 4'd3;
        if (w_sr_iter[13:10] >= 4'd8) w_sr_iter[13:10] = w_sr_iter[13:10] - 4'd3;
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state: only a well-formed operand enters CONV; leave after the 10th step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start && !w_digit_bad) w_state_next = ST_CONV;
            ST_CONV: if (w_last)                w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and handshake registers; done is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_digit_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                            r_bin  <= '0;
                        end else begin
                            r_sr   <= {bcd_in, 10'b0};
                            r_cnt  <= '0;
                            r_err  <= 1'b0;
                            r_busy <= 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    r_sr <= w_sr_iter;
                    if (w_last) begin
                        // Counter returns to 0 so it never exceeds 9.
                        r_cnt  <= '0;
                        r_bin  <= w_sr_iter[9:0];
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin_out = r_bin;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin_converter
// Brief    : Scoreboard bench for bcd_to_bin_converter. Stimulus pushes the
//            expected result and due cycle; a monitor pops on every done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic [9:0]  bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         due;
        logic [11:0] code;
    } exp_t;

    exp_t q[$];

    bcd_to_bin_converter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: after edge En (plus a delta) cyc reads n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bcd_value(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Drive one start pulse; optionally record the expected response.
    task automatic issue(input logic [11:0] v, input bit push, input logic [9:0] eb,
                         input logic ee, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.bin  = eb;
            e.err  = ee;
            e.due  = ee ? cyc : cyc + 10;
            e.code = v;
            q.push_back(e);
        end
        check("busy_after_start", int'(busy), int'(exp_busy));
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 12'($urandom);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bin_out", int'(bin_out), int'(e.bin));
                check("err", int'(err), int'(e.err));
                check("done_latency", cyc, e.due);
                check("busy_in_done", int'(busy), 0);
                if (!e.err)
                    check("bcd_fields_zero", int'(dut.r_sr[21:10]), 0);
            end
        end
    end

    initial begin
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Largest operand.
        issue(12'h999, 1'b1, 10'd999, 1'b0, 1'b1);
        repeat (12) @(posedge clk);

        // Directed small set.
        issue(12'h000, 1'b1, 10'd0,   1'b0, 1'b1); repeat (12) @(posedge clk);
        issue(12'h001, 1'b1, 10'd1,   1'b0, 1'b1); repeat (12) @(posedge clk);
        issue(12'h255, 1'b1, 10'd255, 1'b0, 1'b1); repeat (12) @(posedge clk);
        issue(12'h512, 1'b1, 10'd512, 1'b0, 1'b1); repeat (12) @(posedge clk);

        // Invalid tens digit: immediate done+err, busy never rises.
        issue(12'h1A3, 1'b1, 10'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("invalid_busy_stays_low", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("err_held", int'(err), 1);
        issue(12'h042, 1'b1, 10'd42, 1'b0, 1'b1);
        repeat (12) @(posedge clk);

        // Start while busy is dropped.
        issue(12'h123, 1'b1, 10'd123, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        issue(12'h999, 1'b0, 10'd0, 1'b0, 1'b1);
        repeat (12) @(posedge clk);

        // Reset mid-conversion, during the 5th iteration's cycle.
        issue(12'h777, 1'b1, 10'd777, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check("abort_bin_out", int'(bin_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_abort", seen, 0);

        // Back-to-back: second start lands in the done cycle of the first.
        issue(12'h100, 1'b1, 10'd100, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        issue(12'h250, 1'b1, 10'd250, 1'b0, 1'b1);
        repeat (12) @(posedge clk);

        // Every valid code, issued back-to-back.
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int u = 0; u < 10; u++) begin
                    logic [11:0] code;
                    code = {4'(h), 4'(t), 4'(u)};
                    issue(code, 1'b1, 10'(bcd_value(code)), 1'b0, 1'b1);
                    repeat (10) @(posedge clk);
                end
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
